// File: rtl/uart_rx_fifo_if.sv
// Register-interface side of the UART receive FIFO: byte capture, pop port,
// status and interrupt signals bundled for one connection.
interface uart_rx_fifo_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              rx_end;
  logic [7:0]        rx_data;
  logic              rd_en;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic              flush;
  logic              ovr_clr;
  logic [ADDR_W:0]   thresh;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   level;
  logic              overrun;
  logic              irq;

  modport master (
    output rx_end, rx_data, rd_en, flush, ovr_clr, thresh,
    input  rd_data, rd_valid, empty, full, level, overrun, irq
  );

  modport slave (
    input  rx_end, rx_data, rd_en, flush, ovr_clr, thresh,
    output rd_data, rd_valid, empty, full, level, overrun, irq
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive byte FIFO with level, empty/full, sticky overrun and optional
// level/overrun interrupt (enabled by defining UART_RX_FIFO_IRQ_EN).
module uart_rx_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input logic           clk,
  input logic           reset,
  uart_rx_fifo_if.slave bus
);

  localparam int unsigned LVL_W = ADDR_W + 1;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [LVL_W-1:0]  level_q;
  logic [LVL_W-1:0]  level_next;
  logic              empty_q;
  logic              full_q;
  logic              overrun_q;
  logic              overrun_next;
  logic              irq_q;
  logic              irq_next;
  logic [7:0]        rd_data_q;
  logic              rd_valid_q;
  logic              wr_req;
  logic              rd_req;
  logic              do_wr;
  logic              do_rd;
  logic              ovr_set;

  // Flush masks both requests; a full write is accepted only if a pop frees the slot.
  always_comb begin
    wr_req       = 1'b0;
    rd_req       = 1'b0;
    do_wr        = 1'b0;
    do_rd        = 1'b0;
    ovr_set      = 1'b0;
    level_next   = level_q;
    overrun_next = overrun_q;

    wr_req  = bus.rx_end && !bus.flush;
    rd_req  = bus.rd_en && !bus.flush;
    do_rd   = rd_req && !empty_q;
    do_wr   = wr_req && (!full_q || do_rd);
    ovr_set = wr_req && full_q && !do_rd;

    if (bus.flush) begin
      level_next = '0;
    end else if (do_wr && !do_rd) begin
      level_next = level_q + LVL_W'(1);
    end else if (do_rd && !do_wr) begin
      level_next = level_q - LVL_W'(1);
    end

    overrun_next = ovr_set || (overrun_q && !bus.ovr_clr);
  end

`ifdef UART_RX_FIFO_IRQ_EN
  assign irq_next = ((bus.thresh != '0) && (level_next >= bus.thresh)) || overrun_next;
`else
  logic thresh_unused;
  assign thresh_unused = ^bus.thresh;
  assign irq_next      = 1'b0;
`endif

  // Pointers, level and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overrun_q  <= 1'b0;
      irq_q      <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_wr) wr_ptr <= wr_ptr + ADDR_W'(1);
        if (do_rd) rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      level_q    <= level_next;
      empty_q    <= (level_next == '0);
      full_q     <= (level_next == LVL_W'(DEPTH));
      overrun_q  <= overrun_next;
      irq_q      <= irq_next;
      rd_valid_q <= do_rd;
      if (do_rd) rd_data_q <= mem[rd_ptr];
    end
  end

  // Storage has no reset; a full read+write hits the same slot, old byte is read first.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= bus.rx_data;
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.level    = level_q;
  assign bus.empty    = empty_q;
  assign bus.full     = full_q;
  assign bus.overrun  = overrun_q;
  assign bus.irq      = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16); irq checks follow
// whether UART_RX_FIFO_IRQ_EN is defined.
module tb_uart_rx_fifo;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  uart_rx_fifo_if #(.ADDR_W(4)) bus ();

  uart_rx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    bus.rx_end  = 1'b1;
    bus.rx_data = b;
    cyc();
    bus.rx_end  = 1'b0;
  endtask

  task automatic pop();
    bus.rd_en = 1'b1;
    cyc();
    bus.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    cyc();
    checks++; if (bus.level !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", bus.level); end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", bus.overrun); end
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", bus.rd_valid); end
    checks++; if (bus.rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%h exp=00", bus.rd_data); end
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", bus.irq); end
  endtask

  task automatic test_basic();
    logic [7:0] exp_b [3];
    logic [4:0] exp_lvl;
    exp_b[0] = 8'hA5; exp_b[1] = 8'h3C; exp_b[2] = 8'hFF;
    push(8'hA5); push(8'h3C); push(8'hFF);
    checks++; if (bus.level !== 5'd3) begin failures++; $display("FAIL basic_level3 got=%0d exp=3", bus.level); end
    checks++; if (bus.empty !== 1'b0) begin failures++; $display("FAIL basic_not_empty got=%b exp=0", bus.empty); end
    bus.rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      exp_lvl = 5'(2 - i);
      checks++; if (bus.rd_data !== exp_b[i]) begin failures++; $display("FAIL basic_rd_data[%0d] got=%h exp=%h", i, bus.rd_data, exp_b[i]); end
      checks++; if (bus.rd_valid !== 1'b1) begin failures++; $display("FAIL basic_rd_valid[%0d] got=%b exp=1", i, bus.rd_valid); end
      checks++; if (bus.level !== exp_lvl) begin failures++; $display("FAIL basic_level[%0d] got=%0d exp=%0d", i, bus.level, exp_lvl); end
    end
    bus.rd_en = 1'b0;
    cyc();
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%b exp=0", bus.rd_valid); end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL basic_empty_end got=%b exp=1", bus.empty); end
    checks++; if (bus.rd_data !== 8'hFF) begin failures++; $display("FAIL basic_rd_hold got=%h exp=ff", bus.rd_data); end
    // Read on empty with a same-cycle write: no bypass.
    bus.rd_en = 1'b1; bus.rx_end = 1'b1; bus.rx_data = 8'h55;
    cyc();
    bus.rd_en = 1'b0; bus.rx_end = 1'b0;
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL nobypass_valid got=%b exp=0", bus.rd_valid); end
    checks++; if (bus.rd_data !== 8'hFF) begin failures++; $display("FAIL nobypass_data got=%h exp=ff", bus.rd_data); end
    checks++; if (bus.level !== 5'd1) begin failures++; $display("FAIL nobypass_level got=%0d exp=1", bus.level); end
    pop();
    checks++; if (bus.rd_data !== 8'h55 || bus.rd_valid !== 1'b1) begin failures++; $display("FAIL nobypass_pop got=%h/%b exp=55/1", bus.rd_data, bus.rd_valid); end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 17; i++) begin
      push(8'(i));
      if (i == 15) begin
        checks++; if (bus.full !== 1'b1) begin failures++; $display("FAIL ovr_full16 got=%b exp=1", bus.full); end
        checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL ovr_not_yet got=%b exp=0", bus.overrun); end
      end
    end
    checks++; if (bus.overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", bus.overrun); end
    checks++; if (bus.level !== 5'd16) begin failures++; $display("FAIL ovr_level got=%0d exp=16", bus.level); end
    bus.rx_end = 1'b1; bus.rx_data = 8'hEE; bus.ovr_clr = 1'b1;
    cyc();
    bus.rx_end = 1'b0; bus.ovr_clr = 1'b0;
    checks++; if (bus.overrun !== 1'b1) begin failures++; $display("FAIL ovr_clr_vs_set got=%b exp=1", bus.overrun); end
    bus.ovr_clr = 1'b1;
    cyc();
    bus.ovr_clr = 1'b0;
    checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL ovr_clr got=%b exp=0", bus.overrun); end
    bus.rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc();
      checks++; if (bus.rd_data !== 8'(i) || bus.rd_valid !== 1'b1) begin failures++; $display("FAIL ovr_read[%0d] got=%h/%b exp=%h/1", i, bus.rd_data, bus.rd_valid, 8'(i)); end
    end
    bus.rd_en = 1'b0;
    cyc();
    checks++; if (bus.empty !== 1'b1 || bus.level !== 5'd0) begin failures++; $display("FAIL ovr_drained got=%b/%0d exp=1/0", bus.empty, bus.level); end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
    bus.rx_end = 1'b1; bus.rx_data = 8'h77; bus.rd_en = 1'b1;
    cyc();
    bus.rx_end = 1'b0;
    checks++; if (bus.rd_data !== 8'h20) begin failures++; $display("FAIL fullrw_data got=%h exp=20", bus.rd_data); end
    checks++; if (bus.level !== 5'd16 || bus.full !== 1'b1) begin failures++; $display("FAIL fullrw_level got=%0d/%b exp=16/1", bus.level, bus.full); end
    checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL fullrw_overrun got=%b exp=0", bus.overrun); end
    for (int i = 1; i < 16; i++) begin
      cyc();
      checks++; if (bus.rd_data !== 8'h20 + 8'(i)) begin failures++; $display("FAIL fullrw_read[%0d] got=%h exp=%h", i, bus.rd_data, 8'h20 + 8'(i)); end
    end
    cyc();
    bus.rd_en = 1'b0;
    checks++; if (bus.rd_data !== 8'h77 || bus.rd_valid !== 1'b1) begin failures++; $display("FAIL fullrw_last got=%h/%b exp=77/1", bus.rd_data, bus.rd_valid); end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL fullrw_empty got=%b exp=1", bus.empty); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) push(8'h30 + 8'(i));
    bus.flush = 1'b1; bus.rx_end = 1'b1; bus.rx_data = 8'h99; bus.rd_en = 1'b1;
    cyc();
    bus.flush = 1'b0; bus.rx_end = 1'b0; bus.rd_en = 1'b0;
    checks++; if (bus.level !== 5'd0 || bus.empty !== 1'b1) begin failures++; $display("FAIL flush_level got=%0d/%b exp=0/1", bus.level, bus.empty); end
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL flush_rd_valid got=%b exp=0", bus.rd_valid); end
    checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL flush_no_ovr got=%b exp=0", bus.overrun); end
    for (int i = 0; i < 17; i++) push(8'(i));
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    checks++; if (bus.level !== 5'd0 || bus.full !== 1'b0) begin failures++; $display("FAIL flush_full got=%0d/%b exp=0/0", bus.level, bus.full); end
    checks++; if (bus.overrun !== 1'b1) begin failures++; $display("FAIL flush_keeps_ovr got=%b exp=1", bus.overrun); end
    bus.ovr_clr = 1'b1;
    cyc();
    bus.ovr_clr = 1'b0;
    push(8'h42);
    pop();
    checks++; if (bus.rd_data !== 8'h42 || bus.empty !== 1'b1) begin failures++; $display("FAIL flush_reuse got=%h/%b exp=42/1", bus.rd_data, bus.empty); end
  endtask

  task automatic test_irq();
    bus.thresh = 5'd4;
`ifdef UART_RX_FIFO_IRQ_EN
    for (int i = 0; i < 3; i++) push(8'(i));
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL irq_below got=%b exp=0", bus.irq); end
    push(8'h03);
    checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL irq_rise got=%b exp=1", bus.irq); end
    pop();
    checks++; if (bus.irq !== 1'b0 || bus.level !== 5'd3) begin failures++; $display("FAIL irq_fall got=%b/%0d exp=0/3", bus.irq, bus.level); end
    bus.thresh = 5'd0;
    for (int i = 0; i < 13; i++) push(8'(i));
    checks++; if (bus.irq !== 1'b0 || bus.full !== 1'b1) begin failures++; $display("FAIL irq_thresh0 got=%b/%b exp=0/1", bus.irq, bus.full); end
    push(8'hAA);
    checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL irq_ovr got=%b exp=1", bus.irq); end
    bus.ovr_clr = 1'b1;
    cyc();
    bus.ovr_clr = 1'b0;
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL irq_ovr_clr got=%b exp=0", bus.irq); end
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    bus.thresh = 5'd4;
`else
    for (int i = 0; i < 17; i++) push(8'(i));
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL irq_disabled got=%b exp=0", bus.irq); end
    bus.flush = 1'b1; bus.ovr_clr = 1'b1;
    cyc();
    bus.flush = 1'b0; bus.ovr_clr = 1'b0;
`endif
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) push(8'h60 + 8'(i));
`ifdef UART_RX_FIFO_IRQ_EN
    checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL areset_irq_pre got=%b exp=1", bus.irq); end
`endif
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (bus.level !== 5'd0 || bus.empty !== 1'b1) begin failures++; $display("FAIL areset_level got=%0d/%b exp=0/1", bus.level, bus.empty); end
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL areset_irq got=%b exp=0", bus.irq); end
    cyc();
    reset = 1'b0;
    cyc();
    checks++; if (bus.level !== 5'd0 || bus.rd_data !== 8'h00) begin failures++; $display("FAIL areset_after got=%0d/%h exp=0/00", bus.level, bus.rd_data); end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    bus.rx_end  = 1'b0;
    bus.rx_data = 8'h00;
    bus.rd_en   = 1'b0;
    bus.flush   = 1'b0;
    bus.ovr_clr = 1'b0;
    bus.thresh  = 5'd0;
    test_reset();
    test_basic();
    test_overrun();
    test_full_rw();
    test_flush();
    test_irq();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
